// File: rtl/hilo_sequencer_pkg.sv
// Shared pipeline definitions for the multiply/divide HI/LO sequencer:
// FSM state encoding and default operation latencies.
package hilo_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } md_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 4;
    localparam int unsigned DIV_CYCLES_DEF  = 32;

endpackage

// File: rtl/hilo_sequencer.sv
// Multiply/divide sequencer: starts the arithmetic unit, counts its latency,
// strobes the HI/LO write and stalls HI/LO-dependent instructions held in EX.
module hilo_sequencer
    import hilo_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_valid,
    input  logic ex_mult,
    input  logic ex_div,
    input  logic ex_signed,
    input  logic ex_mfhilo,
    output logic md_start,
    output logic md_op,
    output logic md_signed,
    output logic hilo_we,
    output logic busy,
    output logic pcen,
    output logic ifiden,
    output logic idexen,
    output logic exmembubble
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hilo_we_q;
    logic             hazard;

    // A start seen while reset is held would not advance the FSM, so it is suppressed.
    assign md_start  = ~rst & ex_valid & (ex_mult | ex_div) & (state_q == IDLE);
    assign md_op     = ex_div;
    assign md_signed = ex_signed;

    assign hazard      = ex_valid & (ex_mfhilo | ex_mult | ex_div) & (state_q != IDLE);
    assign pcen        = ~hazard;
    assign ifiden      = ~hazard;
    assign idexen      = ~hazard;
    assign exmembubble = hazard;

    assign busy    = (state_q != IDLE);
    assign hilo_we = hilo_we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hilo_we_q <= 1'b0;
        end else begin
            hilo_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (md_start) begin
                        cnt_q   <= ex_div ? DIV_LOAD : MULT_LOAD;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q   <= WB;
                        hilo_we_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                WB: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/hilo_sequencer.md
# hilo_sequencer

Controller for the multi-cycle multiply/divide unit and its HI/LO register pair in the five-stage semiMIPS pipeline. It issues start commands to the arithmetic unit when a mult/multu/div/divu reaches EX, counts the operation latency, and generates the HI/LO write strobe. While an operation is in flight it stalls any HI/LO-dependent instruction (mfhi, mflo, or a further mult/div) held in EX. It sits beside the load-use hazard detection unit; the pipeline ANDs the two units' enables and ORs their bubble requests.

## Interface
- MULT_CYCLES, 4, busy cycles for a multiply (≥1)
- DIV_CYCLES, 32, busy cycles for a divide (≥1)
- CNT_W, 6, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1
- clk  in  1  pipeline clock
- rst  in  1  reset; one clock, synchronous, active-high
- ex_valid  in  1  ID/EX holds a real (non-bubble) instruction
- ex_mult  in  1  EX instruction is mult/multu
- ex_div  in  1  EX instruction is div/divu
- ex_signed  in  1  signed variant (mult/div)
- ex_mfhilo  in  1  EX instruction is mfhi/mflo
- md_start  out  1  one-cycle start pulse to the arithmetic unit
- md_op  out  1  0 = multiply, 1 = divide; valid with md_start
- md_signed  out  1  signedness; valid with md_start
- hilo_we  out  1  HI/LO capture strobe for the unit's result
- busy  out  1  state != IDLE
- pcen  out  1  PC write enable
- ifiden  out  1  IF/ID register enable
- idexen  out  1  ID/EX register enable (hold EX instruction)
- exmembubble  out  1  force NOP control into EX/MEM

## Operation
- States: IDLE, BUSY, WB. Counter cnt[CNT_W-1:0].
- hazard = ex_valid & (ex_mfhilo | ex_mult | ex_div) & (state != IDLE).
- Stall outputs are combinational: pcen = ifiden = idexen = ~hazard; exmembubble = hazard.
- IDLE:
  - If ex_valid & (ex_mult | ex_div): assert md_start (Mealy, same cycle).
  - md_op = ex_div; md_signed = ex_signed.
  - Load cnt = (ex_div ? DIV_CYCLES : MULT_CYCLES) - 1; next state BUSY.
  - ex_mult & ex_div both high is illegal; divide wins.
  - A start instruction is not stalled; it leaves EX normally.
- BUSY: if cnt == 0, go to WB; else decrement cnt. No start is accepted.
- WB: assert hilo_we for exactly this cycle, then go to IDLE.
  - An mfhi/mflo or mult/div in EX during WB is still stalled, so it reads or overwrites HI/LO only after the write.
- mfhi/mflo in IDLE: no stall, no action.
- A bubble (ex_valid = 0) never starts or stalls, whatever the type bits say.
- rst, including mid-operation: state IDLE, cnt 0.
  - In-flight operation is abandoned; no hilo_we is produced.
  - Registered outputs clear; stall outputs follow the rule above, so the result is pcen = 1, exmembubble = 0 unless a hazard exists.

## Timing
- Start cycle t (md_start = 1).
- BUSY for cycles t+1 … t+N, where N = MULT_CYCLES or DIV_CYCLES.
- WB (hilo_we = 1) at cycle t+N+1; IDLE from cycle t+N+2.
- A dependent instruction entering EX at any cycle in t+1 … t+N+1 is held until cycle t+N+2, then proceeds.
- Back-to-back mult/div: the second one starts at cycle t+N+2.
- busy is combinational from state and is high for cycles t+1 … t+N+1.
- All state updates occur on the rising edge of clk. No combinational path exists from md_start back into the stall outputs.

## Structure
- Shared package (pipeline defs) holds:
  - state encoding: IDLE = 2'd0, BUSY = 2'd1, WB = 2'd2
  - default latency constants: MULT_CYCLES, DIV_CYCLES
- No sub-modules needed. Datapath: a single down-counter plus a 3-state FSM.
- Stall/bubble decode stays in this module.
- The top level merges the stall and bubble outputs with hazarddetectionunit's outputs.

## Test plan
- Multiply, N = 4: ex_mult = 1 at t0.
  - Required: md_start = 1 and md_op = 0 at t0; busy t1–t5; hilo_we only at t5; pcen = 1 throughout.
- mfhi immediately after mult: ex_mfhilo held in EX from t1.
  - Required: pcen = ifiden = idexen = 0 and exmembubble = 1 for t1–t5; pcen = 1 at t6.
- Divide, DIV_CYCLES = 32, signed.
  - Required: md_op = 1 and md_signed = 1 at t0; hilo_we at t33; a second div in EX at t1 starts at t34.
- Bubble with stray type bits: ex_valid = 0, ex_div = 1 in IDLE and in BUSY.
  - Required: no md_start, no stall.
- rst asserted at t3 of a multiply.
  - Required: state IDLE at t4; hilo_we never asserts; a fresh mult at t5 starts normally.
- ex_mult = ex_div = 1 together.
  - Required: md_op = 1 and the divide latency is used.
